// File: rtl/tone_sequencer_player.sv
// Square-wave tone player: one note from a tone table, timed in duration units,
// followed by a silent gap; start/busy/done handshake with abort and error pulse.
//
// state | meaning
// IDLE  | waiting for a legal start request
// PLAY  | square wave running for dur*TICK_DIV cycles
// GAP   | silent gap of GAP_UNITS*TICK_DIV cycles before done
module tone_sequencer_player #(
  parameter int SEL_W     = 4,
  parameter int NUM_TONES = 4,
  parameter int HALF_BASE = 2,
  parameter int HALF_STEP = 1,
  parameter int DUR_W     = 8,
  parameter int TICK_DIV  = 4,
  parameter int GAP_UNITS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEL_W-1:0] sound_select,
  input  logic [DUR_W-1:0] duration,
  input  logic             start,
  input  logic             stop,
  output logic             sound_output,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int HMAX  = HALF_BASE + (NUM_TONES - 1) * HALF_STEP;
  localparam int PH_W  = (HMAX > 1) ? $clog2(HMAX) : 1;
  localparam int NMAX  = ((2 ** DUR_W) - 1) * TICK_DIV;
  localparam int GMAX  = GAP_UNITS * TICK_DIV;
  localparam int CMAX  = (NMAX > GMAX) ? NMAX : GMAX;
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam int G_M1  = (GMAX > 0) ? GMAX - 1 : 0;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [PH_W-1:0]   half_q, half_d;
  logic              tone_q, tone_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              req_legal;
  logic [PH_W-1:0]   half_new;
  logic [CNT_W-1:0]  play_len_m1;

  // half_q holds H-1 so the phase counter reloads without an adder in PLAY
  assign req_legal   = (int'(sound_select) < NUM_TONES) && (duration != '0);
  assign half_new    = PH_W'(HALF_BASE - 1) + PH_W'(sound_select) * PH_W'(HALF_STEP);
  assign play_len_m1 = CNT_W'(duration) * CNT_W'(TICK_DIV) - CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ph_q    <= '0;
      half_q  <= '0;
      tone_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      half_q  <= half_d;
      tone_q  <= tone_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    half_d  = half_q;
    tone_d  = tone_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        tone_d = 1'b0;
        busy_d = 1'b0;
        if (start && !stop) begin
          if (req_legal) begin
            state_d = PLAY;
            half_d  = half_new;
            ph_d    = half_new;
            cnt_d   = play_len_m1;
            tone_d  = 1'b1;
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PLAY: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
          ph_d    = '0;
          tone_d  = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt_q == '0) begin
          tone_d = 1'b0;
          ph_d   = '0;
          if (GAP_UNITS > 0) begin
            state_d = GAP;
            cnt_d   = CNT_W'(G_M1);
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (ph_q == '0) begin
            tone_d = ~tone_q;
            ph_d   = half_q;
          end else begin
            ph_d = ph_q - PH_W'(1);
          end
        end
      end
      GAP: begin
        tone_d = 1'b0;
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tone_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign sound_output = tone_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_tone_sequencer_player.sv
// Scoreboard bench for tone_sequencer_player: per-cycle expected {sound,busy,done,err}
// vectors are queued when a request is driven and compared as cycles elapse.
module tb_tone_sequencer_player;

  localparam int TICK = 4;
  localparam int GAPC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sound_select = '0;
  logic [7:0] duration = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       sound_output, busy, done, err;

  logic [3:0] exp_q[$];
  int         n_chk = 0;
  int         n_pass = 0;

  tone_sequencer_player dut (
    .clk(clk), .reset(reset), .sound_select(sound_select), .duration(duration),
    .start(start), .stop(stop), .sound_output(sound_output), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got {snd,busy,done,err}=%b expected %b at %0t", tag, obs, exp_v, $time);
  endtask

  // Independent model of one note: wave high for h, low for h, cut after n cycles.
  task automatic push_note(input int h, input int n, input int g);
    for (int k = 0; k < n; k++) exp_q.push_back({((k / h) % 2 == 0) ? 1'b1 : 1'b0, 3'b100});
    for (int k = 0; k < g; k++) exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0010);
  endtask

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(4'b0000);
  endtask

  // Advances one cycle per queued entry; request lines drop after the first edge.
  task automatic drain(input string tag, input int max_n);
    logic [3:0] e;
    int         cnt = 0;
    while (exp_q.size() > 0 && cnt < max_n) begin
      @(posedge clk); #1;
      start = 1'b0;
      stop  = 1'b0;
      e = exp_q.pop_front();
      chk(tag, {sound_output, busy, done, err}, e);
      cnt++;
    end
  endtask

  task automatic req(input logic [3:0] s, input logic [7:0] d);
    sound_select = s;
    duration     = d;
    start        = 1'b1;
  endtask

  initial begin
    #1;
    chk("reset_state", {sound_output, busy, done, err}, 4'b0000);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // sel=0, dur=3: H=2, 12 play cycles, 4 gap, done on cycle 17
    req(4'd0, 8'd3);
    push_note(2, 3 * TICK, GAPC);
    drain("note_sel0_dur3", 100);

    push_idle(1);
    drain("idle_after_done", 100);

    // sel=1, dur=2: H=3, 8 play cycles
    req(4'd1, 8'd2);
    push_note(3, 2 * TICK, GAPC);
    drain("note_sel1_dur2", 100);

    // highest legal tone: H=5, dur=1 cuts the wave before the first toggle
    req(4'd3, 8'd1);
    push_note(5, 1 * TICK, GAPC);
    drain("note_sel3_dur1", 100);

    req(4'd4, 8'd2);
    exp_q.push_back(4'b0001);
    push_idle(2);
    drain("err_bad_sel", 100);

    req(4'd0, 8'd0);
    exp_q.push_back(4'b0001);
    push_idle(2);
    drain("err_zero_dur", 100);

    // start ignored while busy, then abort on PLAY cycle 5
    req(4'd0, 8'd3);
    for (int k = 0; k < 3; k++) exp_q.push_back({((k / 2) % 2 == 0) ? 1'b1 : 1'b0, 3'b100});
    drain("play_before_ignored_start", 100);
    req(4'd2, 8'd5);
    for (int k = 3; k < 5; k++) exp_q.push_back({((k / 2) % 2 == 0) ? 1'b1 : 1'b0, 3'b100});
    drain("play_after_ignored_start", 100);
    stop = 1'b1;
    push_idle(6);
    drain("stop_in_play", 100);

    // start issued during the done cycle is taken immediately
    req(4'd0, 8'd1);
    push_note(2, 1 * TICK, GAPC);
    drain("note_before_b2b", 100);
    req(4'd1, 8'd1);
    push_note(3, 1 * TICK, GAPC);
    drain("note_b2b", 100);

    req(4'd0, 8'd2);
    stop = 1'b1;
    push_idle(3);
    drain("start_with_stop_idle", 100);

    // reset asserted while the wave is high clears outputs without an edge
    req(4'd2, 8'd4);
    exp_q.push_back(4'b1100);
    drain("note_before_reset", 100);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    chk("async_reset_mid_note", {sound_output, busy, done, err}, 4'b0000);
    @(posedge clk); #1;
    chk("reset_held", {sound_output, busy, done, err}, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    push_idle(3);
    drain("after_reset", 100);

    if (exp_q.size() != 0) chk("scoreboard_empty", 4'(exp_q.size()), 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
